reg_file_mp: RTL and testbench

- Parametrised multi-port register file for the pico MIPS datapath.
- Replaces the 2-read/1-write register file.
- N-bit by M-entry storage with NR combinational read ports, two write ports, and a fixed priority between them.
- Same-cycle write-to-read bypass, so the decode stage sees results being retired in the current cycle.
- Register 0 is hardwired to zero.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_mp_if.sv | 31 +++
 rtl/reg_file_read_port.sv | 54 +++++
 rtl/reg_file_mp.sv | 69 ++++++
 tb/tb_reg_file_mp.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Optional scoreboard is controlled by REG_FILE_SCOREBOARD_EN (see reg_file_mp).
package reg_file_pkg;

  localparam int NW = 2;
  localparam int W0 = 0;
  localparam int W1 = 1;

  // One-hot bypass select from per-write-port address hits; W1 outranks W0,
  // matching the write priority so a bypassed value equals next cycle's stored value.
  function automatic logic [NW-1:0] bypass_sel(input logic [NW-1:0] hit);
    bypass_sel = '0;
    if (hit[W1])      bypass_sel[W1] = 1'b1;
    else if (hit[W0]) bypass_sel[W0] = 1'b1;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write/reserve bus of the multi-port register file.
// Reserve and pending signals only take effect with REG_FILE_SCOREBOARD_EN.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int N  = 8,
  parameter int M  = 32,
  parameter int NR = 2,
  parameter int A  = $clog2(M)
);

  logic [NR-1:0][A-1:0] Ra;
  logic [NR-1:0][N-1:0] Ra_data;
  logic [NW-1:0][A-1:0] Rd;
  logic [NW-1:0][N-1:0] Wdata;
  logic [NW-1:0]        w_enable;
  logic [A-1:0]         Rsv;
  logic                 rsv_enable;
  logic [NR-1:0]        Ra_pending;

  modport master (
    output Ra, Rd, Wdata, w_enable, Rsv, rsv_enable,
    input  Ra_data, Ra_pending
  );

  modport slave (
    input  Ra, Rd, Wdata, w_enable, Rsv, rsv_enable,
    output Ra_data, Ra_pending
  );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port: zero-register check, write bypass, pending flag.
// Pending logic is built only with REG_FILE_SCOREBOARD_EN.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int N = 8,
  parameter int A = 5
) (
  input  logic                 i_rst_n,
  input  logic [A-1:0]         i_ra,
  input  logic [NW-1:0][A-1:0] i_rd,
  input  logic [NW-1:0][N-1:0] i_wdata,
  input  logic [NW-1:0]        i_wen,
  input  logic [N-1:0]         i_stored,
  input  logic [A-1:0]         i_rsv,
  input  logic                 i_rsv_en,
  input  logic                 i_pend_stored,
  output logic [N-1:0]         o_data,
  output logic                 o_pending
);

  logic [NW-1:0] w_hit;
  logic [NW-1:0] w_sel;
  logic          w_ra_nz;

  assign w_ra_nz = (i_ra != '0);

  always_comb begin
    for (int p = 0; p < NW; p++)
      w_hit[p] = i_wen[p] && (i_rd[p] == i_ra) && w_ra_nz;
  end

  assign w_sel = bypass_sel(w_hit);

  always_comb begin
    o_data = '0;
    if (i_rst_n && w_ra_nz) begin
      if (w_sel[W1])      o_data = i_wdata[W1];
      else if (w_sel[W0]) o_data = i_wdata[W0];
      else                o_data = i_stored;
    end
  end

`ifdef REG_FILE_SCOREBOARD_EN
  logic w_rsv_hit;
  assign w_rsv_hit = i_rsv_en && (i_rsv == i_ra) && w_ra_nz;
  // A retiring write hides the pending bit unless a new producer reserves the same register.
  assign o_pending = i_rst_n && w_ra_nz && i_pend_stored && !((|w_hit) && !w_rsv_hit);
`else
  wire w_unused = &{1'b0, i_rsv, i_rsv_en, i_pend_stored};
  assign o_pending = 1'b0;
`endif

endmodule

// File: rtl/reg_file_mp.sv
// M x N register file, NR combinational read ports, two prioritised write ports (W1 wins).
// Define REG_FILE_SCOREBOARD_EN to build the per-register pending scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int N  = 8,
  parameter int M  = 32,
  parameter int NR = 2
) (
  input  logic          clk,
  input  logic          n_reset,
  reg_file_mp_if.slave  bus
);

  localparam int A = $clog2(M);

  logic [M-1:0][N-1:0] r_regs;

  // Ascending port order makes W1 the last assignment, so it wins a same-address conflict.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_regs <= '0;
    end else begin
      for (int p = 0; p < NW; p++)
        if (bus.w_enable[p] && (bus.Rd[p] != '0))
          r_regs[bus.Rd[p]] <= bus.Wdata[p];
    end
  end

`ifdef REG_FILE_SCOREBOARD_EN
  logic [M-1:0] r_pend;

  // Reserve is applied after the write clears so a same-cycle reserve keeps the bit set.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_pend <= '0;
    end else begin
      for (int p = 0; p < NW; p++)
        if (bus.w_enable[p])
          r_pend[bus.Rd[p]] <= 1'b0;
      if (bus.rsv_enable && (bus.Rsv != '0))
        r_pend[bus.Rsv] <= 1'b1;
    end
  end
`endif

  for (genvar r = 0; r < NR; r++) begin : g_rp
    logic w_pend_stored;
`ifdef REG_FILE_SCOREBOARD_EN
    assign w_pend_stored = r_pend[bus.Ra[r]];
`else
    assign w_pend_stored = 1'b0;
`endif
    reg_file_read_port #(.N(N), .A(A)) u_rp (
      .i_rst_n       (n_reset),
      .i_ra          (bus.Ra[r]),
      .i_rd          (bus.Rd),
      .i_wdata       (bus.Wdata),
      .i_wen         (bus.w_enable),
      .i_stored      (r_regs[bus.Ra[r]]),
      .i_rsv         (bus.Rsv),
      .i_rsv_en      (bus.rsv_enable),
      .i_pend_stored (w_pend_stored),
      .o_data        (bus.Ra_data[r]),
      .o_pending     (bus.Ra_pending[r])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed vector table, reset/scoreboard sequences,
// and randomized traffic against an array-based reference model.
module tb_reg_file_mp;

  localparam int N  = 8;
  localparam int M  = 32;
  localparam int NR = 2;

  logic clk;
  logic n_reset;

  reg_file_mp_if #(.N(N), .M(M), .NR(NR)) bus ();

  reg_file_mp #(.N(N), .M(M), .NR(NR)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] mem  [M];
  bit           pend [M];

  typedef struct {
    string        name;
    logic [1:0]   we;
    logic [4:0]   rd0, rd1;
    logic [7:0]   wd0, wd1;
    logic [4:0]   ra0, ra1;
    logic [7:0]   e0, e1;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] rd0, input logic [7:0] wd0,
                       input logic [4:0] rd1, input logic [7:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    bus.w_enable = we;
    bus.Rd[0] = rd0;  bus.Wdata[0] = wd0;
    bus.Rd[1] = rd1;  bus.Wdata[1] = wd1;
    bus.Ra[0] = ra0;  bus.Ra[1] = ra1;
    bus.rsv_enable = 1'b0;
    bus.Rsv = '0;
  endtask

  function automatic logic [N-1:0] ref_read(input logic [4:0] ra);
    if (ra == 0) return '0;
    if (bus.w_enable[1] && bus.Rd[1] == ra) return bus.Wdata[1];
    if (bus.w_enable[0] && bus.Rd[0] == ra) return bus.Wdata[0];
    return mem[ra];
  endfunction

  function automatic logic ref_pend(input logic [4:0] ra);
    logic wr_hit, rs_hit;
    if (ra == 0) return 1'b0;
    wr_hit = (bus.w_enable[1] && bus.Rd[1] == ra) || (bus.w_enable[0] && bus.Rd[0] == ra);
    rs_hit = bus.rsv_enable && bus.Rsv == ra;
    return pend[ra] && !(wr_hit && !rs_hit);
  endfunction

  // Apply one clock edge, updating the model from the inputs that are live at the edge.
  task automatic tick();
    if (n_reset) begin
      for (int p = 0; p < 2; p++)
        if (bus.w_enable[p] && bus.Rd[p] != 0) begin
          mem[bus.Rd[p]]  = bus.Wdata[p];
          pend[bus.Rd[p]] = 1'b0;
        end
      if (bus.rsv_enable && bus.Rsv != 0) pend[bus.Rsv] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < M; i++) begin
      mem[i]  = '0;
      pend[i] = 1'b0;
    end
  endtask

  task automatic add(input string nm, input logic [1:0] we, input logic [4:0] rd0, input logic [7:0] wd0,
                     input logic [4:0] rd1, input logic [7:0] wd1, input logic [4:0] ra0,
                     input logic [4:0] ra1, input logic [7:0] e0, input logic [7:0] e1);
    vec_t v;
    v.name = nm; v.we = we; v.rd0 = rd0; v.wd0 = wd0; v.rd1 = rd1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1;
    vecs.push_back(v);
  endtask

  initial begin
    model_reset();
    n_reset = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 5, 31);
    #12;
    check("reset_rd0", bus.Ra_data[0], 0);
    check("reset_rd1", bus.Ra_data[1], 0);
    check("reset_pend", bus.Ra_pending, 0);
    @(negedge clk);
    n_reset = 1'b1;
    #1;

    //   name             we     rd0 wd0  rd1 wd1  ra0 ra1  e0   e1
    add("r0_write_same",  2'b01, 0,  133, 0,  0,   0,  0,   0,   0);
    add("r0_write_after", 2'b00, 0,  0,   0,  0,   0,  31,  0,   0);
    add("r31_bypass",     2'b10, 0,  0,   31, 233, 31, 0,   233, 0);
    add("r31_stored",     2'b00, 0,  0,   0,  0,   31, 0,   233, 0);
    add("r22_bypass",     2'b01, 22, 77,  0,  0,   22, 22,  77,  77);
    add("r22_stored",     2'b00, 0,  0,   0,  0,   22, 31,  77,  233);
    add("conflict_byp",   2'b11, 7,  10,  7,  20,  7,  7,   20,  20);
    add("conflict_str",   2'b00, 0,  0,   0,  0,   7,  7,   20,  20);
    add("dual_byp",       2'b11, 1,  1,   2,  2,   1,  2,   1,   2);
    add("dual_str",       2'b00, 0,  0,   0,  0,   1,  2,   1,   2);
    add("w1_to_r0_w0_r3", 2'b11, 3,  44,  0,  99,  3,  0,   44,  0);
    add("r3_stored",      2'b00, 0,  0,   0,  0,   3,  22,  44,  77);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].rd0, vecs[i].wd0, vecs[i].rd1, vecs[i].wd1, vecs[i].ra0, vecs[i].ra1);
      #1;
      check({vecs[i].name, "_p0"}, bus.Ra_data[0], vecs[i].e0);
      check({vecs[i].name, "_p1"}, bus.Ra_data[1], vecs[i].e1);
      tick();
    end

    // Asynchronous reset mid-cycle, with a write held active through the edge.
    drive(2'b01, 5, 55, 0, 0, 5, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 5, 0);
    #1;
    check("r5_before_reset", bus.Ra_data[0], 55);
    #1;
    n_reset = 1'b0;
    #1;
    check("r5_async_reset", bus.Ra_data[0], 0);
    drive(2'b01, 5, 99, 0, 0, 5, 0);
    #1;
    check("bypass_in_reset", bus.Ra_data[0], 0);
    @(posedge clk);
    #1;
    check("write_in_reset", bus.Ra_data[0], 0);
    drive(2'b00, 0, 0, 0, 0, 5, 31);
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
    #1;
    check("r5_after_reset", bus.Ra_data[0], 0);
    check("r31_after_reset", bus.Ra_data[1], 0);

`ifdef REG_FILE_SCOREBOARD_EN
    drive(2'b00, 0, 0, 0, 0, 9, 9);
    bus.rsv_enable = 1'b1; bus.Rsv = 9;
    #1;
    check("rsv_not_yet", bus.Ra_pending[0], 0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 9, 9);
    #1;
    check("rsv_pending", bus.Ra_pending[0], 1);
    drive(2'b10, 0, 0, 9, 66, 9, 9);
    #1;
    check("wr_hides_pend", bus.Ra_pending[1], 0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 9, 9);
    #1;
    check("pend_cleared", bus.Ra_pending[0], 0);
    drive(2'b01, 9, 67, 0, 0, 9, 9);
    bus.rsv_enable = 1'b1; bus.Rsv = 9;
    tick();
    drive(2'b00, 0, 0, 0, 0, 9, 0);
    #1;
    check("rsv_beats_wr", bus.Ra_pending[0], 1);
    check("r0_never_pend", bus.Ra_pending[1], 0);
`endif

    for (int it = 0; it < 400; it++) begin
      logic [4:0] hi;
      hi = (it % 2 == 0) ? 5'd7 : 5'd31;
      drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, hi)), 8'($urandom),
            5'($urandom_range(0, hi)), 8'($urandom),
            5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)));
      bus.rsv_enable = 1'($urandom_range(0, 1));
      bus.Rsv = 5'($urandom_range(0, hi));
      #1;
      for (int r = 0; r < NR; r++) begin
        check($sformatf("rand_rd%0d", r), bus.Ra_data[r], ref_read(bus.Ra[r]));
`ifdef REG_FILE_SCOREBOARD_EN
        check($sformatf("rand_pend%0d", r), bus.Ra_pending[r], ref_pend(bus.Ra[r]));
`else
        check($sformatf("rand_pend%0d", r), bus.Ra_pending[r], 0);
`endif
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
